// File: rtl/midi_voice_scheduler.sv
// ---------------------------------------------------------------------------
// MidiVoiceScheduler (module midi_voice_scheduler)
//
// Purpose:
//   Takes parsed MIDI note-on / note-off events and assigns them to a bank of
//   NUMVOICES synthesis voices. For every accepted note-on it also runs the
//   shared note-number -> phase-increment lookup, which is a single-port ROM
//   with one cycle of read latency. The result is then loaded into the chosen
//   voice.
//
// Optional feature (compile-time macro VOICE_STEAL_EN):
//   defined   - when every voice is busy, a note-on steals the voice at a
//               round-robin pointer; ev_dropped is never raised.
//   undefined - when every voice is busy, the note-on is discarded and
//               ev_dropped pulses for one cycle.
//
// Ports:
//   clk              system clock
//   reset_n          synchronous active-low reset
//   ev_valid         event valid
//   ev_ready         scheduler can accept an event (IDLE and out of reset)
//   ev_note_on       1 = note-on, 0 = note-off
//   ev_note          MIDI note number
//   lut_notenum      note number presented to the phase-increment lookup
//   lut_phase_inc    lookup result, valid one cycle after lut_notenum
//   voice_gate       per-voice gate
//   voice_note       note held by each voice
//   voice_phase_inc  per-voice phase increment
//   voice_update     one-cycle strobe: voice i was just loaded
//   ev_dropped       one-cycle strobe: note-on discarded (all voices busy)
// ---------------------------------------------------------------------------
module midi_voice_scheduler #(
    parameter int NUMVOICES = 4,
    parameter int PI_WIDTH  = 32
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 ev_valid,
    output logic                                 ev_ready,
    input  logic                                 ev_note_on,
    input  logic [6:0]                           ev_note,
    output logic [6:0]                           lut_notenum,
    input  logic [PI_WIDTH-1:0]                  lut_phase_inc,
    output logic [NUMVOICES-1:0]                 voice_gate,
    output logic [NUMVOICES-1:0][6:0]            voice_note,
    output logic [NUMVOICES-1:0][PI_WIDTH-1:0]   voice_phase_inc,
    output logic [NUMVOICES-1:0]                 voice_update,
    output logic                                 ev_dropped
);

    localparam int VW = (NUMVOICES > 1) ? $clog2(NUMVOICES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            active;
    logic [VW-1:0]   sel_voice;
    logic [VW-1:0]   next_sel;
    logic            accept;
    logic            start_on;
    logic            drop_note;
    logic [NUMVOICES-1:0] hit;
    logic            hit_any;
    logic [VW-1:0]   hit_idx;
    logic            free_any;
    logic [VW-1:0]   free_idx;
    logic [NUMVOICES-1:0] clear_mask;
`ifdef VOICE_STEAL_EN
    logic [VW-1:0]   steal_ptr;
    logic            steal;
`endif

    // 'active' keeps ev_ready low in the cycle right after a reset edge,
    // so every output reads 0 while reset is being applied.
    assign ev_ready = active && (state == IDLE);
    assign accept   = ev_valid && ev_ready;

    // Scan the voices from the top down so that the lowest index wins for
    // both the retrigger match and the first free slot.
    always_comb begin
        hit      = '0;
        hit_any  = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = NUMVOICES - 1; i >= 0; i--) begin
            if (voice_gate[i] && (voice_note[i] == ev_note)) begin
                hit[i]  = 1'b1;
                hit_any = 1'b1;
                hit_idx = VW'(i);
            end
            if (!voice_gate[i]) begin
                free_any = 1'b1;
                free_idx = VW'(i);
            end
        end
    end

    // A note-off clears every gated voice that holds the note, in a single cycle.
    assign clear_mask = (accept && !ev_note_on) ? hit : '0;

    // Next-state and voice selection. Priority: retrigger, free slot, then
    // either steal or drop, depending on the build.
    always_comb begin
        state_next = state;
        start_on   = 1'b0;
        drop_note  = 1'b0;
        next_sel   = free_idx;
`ifdef VOICE_STEAL_EN
        steal      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept && ev_note_on) begin
                    if (hit_any) begin
                        next_sel = hit_idx;
                        start_on = 1'b1;
                    end else if (free_any) begin
                        next_sel = free_idx;
                        start_on = 1'b1;
                    end else begin
`ifdef VOICE_STEAL_EN
                        next_sel = steal_ptr;
                        start_on = 1'b1;
                        steal    = 1'b1;
`else
                        drop_note = 1'b1;
`endif
                    end
                end
                if (start_on) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP:  state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, lookup address and the voice bank. lut_notenum doubles as the
    // latched note: it is loaded only when a note-on is accepted, and it
    // still holds that note during CAPTURE, when the voice is written.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            active          <= 1'b0;
            sel_voice       <= '0;
            lut_notenum     <= '0;
            voice_gate      <= '0;
            voice_note      <= '0;
            voice_phase_inc <= '0;
            voice_update    <= '0;
            ev_dropped      <= 1'b0;
        end else begin
            state        <= state_next;
            active       <= 1'b1;
            voice_update <= '0;
            ev_dropped   <= drop_note;
            voice_gate   <= voice_gate & ~clear_mask;
            if (start_on) begin
                sel_voice   <= next_sel;
                lut_notenum <= ev_note;
            end
            if (state == CAPTURE) begin
                voice_phase_inc[sel_voice] <= lut_phase_inc;
                voice_note[sel_voice]      <= lut_notenum;
                voice_gate[sel_voice]      <= 1'b1;
                voice_update[sel_voice]    <= 1'b1;
            end
        end
    end

`ifdef VOICE_STEAL_EN
    // Round-robin steal pointer. It advances only when a voice is actually stolen.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            steal_ptr <= '0;
        end else if (steal) begin
            if (steal_ptr == VW'(NUMVOICES - 1)) begin
                steal_ptr <= '0;
            end else begin
                steal_ptr <= steal_ptr + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_midi_voice_scheduler.sv
// ---------------------------------------------------------------------------
// tb_midi_voice_scheduler
//
// Purpose:
//   Self-checking bench for midi_voice_scheduler. It contains a behavioural
//   phase-increment ROM with one cycle of latency and a reference model of
//   the voice bank. Each completed note-on is scored through a queue of
//   expected voice loads, which is popped whenever voice_update fires.
//
// Ports: none (top-level bench). It follows VOICE_STEAL_EN in the same way
// as the design.
// ---------------------------------------------------------------------------
module tb_midi_voice_scheduler;

    localparam int NV = 4;
    localparam int PW = 32;

    logic                    clk;
    logic                    reset_n;
    logic                    ev_valid;
    logic                    ev_ready;
    logic                    ev_note_on;
    logic [6:0]              ev_note;
    logic [6:0]              lut_notenum;
    logic [PW-1:0]           lut_phase_inc;
    logic [NV-1:0]           voice_gate;
    logic [NV-1:0][6:0]      voice_note;
    logic [NV-1:0][PW-1:0]   voice_phase_inc;
    logic [NV-1:0]           voice_update;
    logic                    ev_dropped;

    typedef struct {
        int            idx;
        logic [6:0]    note;
        logic [PW-1:0] pi;
        logic [NV-1:0] gate;
    } exp_t;

    exp_t           sb_q[$];
    int             n_checks = 0;
    int             n_fail   = 0;
    int             drop_seen = 0;
    int             drop_exp  = 0;

    logic [NV-1:0]         m_gate;
    logic [6:0]            m_note [NV];
    logic [PW-1:0]         m_pi   [NV];
    int                    m_steal;

    midi_voice_scheduler #(.NUMVOICES(NV), .PI_WIDTH(PW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ev_valid        (ev_valid),
        .ev_ready        (ev_ready),
        .ev_note_on      (ev_note_on),
        .ev_note         (ev_note),
        .lut_notenum     (lut_notenum),
        .lut_phase_inc   (lut_phase_inc),
        .voice_gate      (voice_gate),
        .voice_note      (voice_note),
        .voice_phase_inc (voice_phase_inc),
        .voice_update    (voice_update),
        .ev_dropped      (ev_dropped)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phase-increment table. Note 60 maps to a fixed marker value; every
    // other note gets a distinct value.
    function automatic logic [PW-1:0] lutf(input logic [6:0] n);
        if (n == 7'd60) return 32'h0123_4567;
        return ({25'd0, n} << 20) ^ 32'h00A5_5A5A ^ {25'd0, n};
    endfunction

    // Single-port lookup ROM with one cycle of read latency.
    always @(posedge clk) lut_phase_inc <= lutf(lut_notenum);

    // Counts the comparison and reports it if the observed value differs from the expected one.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: each voice_update must match the oldest expected load.
    always @(negedge clk) begin
        if (ev_dropped === 1'b1) drop_seen++;
        if (voice_update !== '0) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_update", 64'(voice_update), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("upd_vec", 64'(voice_update), 64'(NV'(1) << e.idx));
                checkOutput("upd_note", 64'(voice_note[e.idx]), 64'(e.note));
                checkOutput("upd_pi", 64'(voice_phase_inc[e.idx]), 64'(e.pi));
                checkOutput("upd_gate", 64'(voice_gate), 64'(e.gate));
            end
        end
    end

    task automatic modelReset();
        m_gate  = '0;
        m_steal = 0;
        for (int i = 0; i < NV; i++) begin
            m_note[i] = '0;
            m_pi[i]   = '0;
        end
    endtask

    // Compares the whole voice bank against the model.
    task automatic checkVoices(input string tag);
        checkOutput({tag, "_gate"}, 64'(voice_gate), 64'(m_gate));
        for (int i = 0; i < NV; i++) begin
            checkOutput($sformatf("%s_note%0d", tag, i), 64'(voice_note[i]), 64'(m_note[i]));
            checkOutput($sformatf("%s_pi%0d", tag, i), 64'(voice_phase_inc[i]), 64'(m_pi[i]));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready"}, 64'(ev_ready), 64'd0);
        checkOutput({tag, "_lut"}, 64'(lut_notenum), 64'd0);
        checkOutput({tag, "_upd"}, 64'(voice_update), 64'd0);
        checkOutput({tag, "_drop"}, 64'(ev_dropped), 64'd0);
        checkOutput({tag, "_gate"}, 64'(voice_gate), 64'd0);
        for (int i = 0; i < NV; i++) begin
            checkOutput($sformatf("%s_note%0d", tag, i), 64'(voice_note[i]), 64'd0);
            checkOutput($sformatf("%s_pi%0d", tag, i), 64'(voice_phase_inc[i]), 64'd0);
        end
    endtask

    // Waits (bounded) until ev_ready is high, with time 1 ns past a rising edge.
    task automatic waitReady();
        int budget = 0;
        while (ev_ready !== 1'b1 && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        if (ev_ready !== 1'b1) checkOutput("ready_timeout", 64'(ev_ready), 64'd1);
    endtask

    task automatic doReset();
        reset_n  = 1'b0;
        ev_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("rst");
        reset_n = 1'b1;
        modelReset();
        @(posedge clk); #1;
        checkOutput("rst_ready_after", 64'(ev_ready), 64'd1);
    endtask

    // Drives one event and checks the cycle-level behaviour. For note-ons it
    // returns in the cycle after CAPTURE, when the scheduler is ready again.
    task automatic applyStimulus(input logic on, input logic [6:0] note);
        int  sel;
        bit  drop;
        waitReady();
        sel  = -1;
        drop = 1'b0;
        if (on) begin
            for (int i = 0; i < NV; i++)
                if (sel < 0 && m_gate[i] && m_note[i] == note) sel = i;
            for (int i = 0; i < NV; i++)
                if (sel < 0 && !m_gate[i]) sel = i;
            if (sel < 0) begin
`ifdef VOICE_STEAL_EN
                sel     = m_steal;
                m_steal = (m_steal + 1) % NV;
`else
                drop = 1'b1;
`endif
            end
        end
        ev_valid   = 1'b1;
        ev_note_on = on;
        ev_note    = note;
        @(posedge clk); #1;
        ev_valid = 1'b0;
        if (!on) begin
            for (int i = 0; i < NV; i++)
                if (m_gate[i] && m_note[i] == note) m_gate[i] = 1'b0;
            checkOutput("off_ready", 64'(ev_ready), 64'd1);
            checkVoices("off");
        end else if (drop) begin
            drop_exp++;
            checkOutput("drop_pulse", 64'(ev_dropped), 64'd1);
            checkOutput("drop_ready", 64'(ev_ready), 64'd1);
            checkVoices("drop");
        end else begin
            exp_t e;
            m_gate[sel] = 1'b1;
            m_note[sel] = note;
            m_pi[sel]   = lutf(note);
            e.idx  = sel;
            e.note = note;
            e.pi   = lutf(note);
            e.gate = m_gate;
            sb_q.push_back(e);
            checkOutput("on_lut_t1", 64'(lut_notenum), 64'(note));
            checkOutput("on_ready_t1", 64'(ev_ready), 64'd0);
            checkOutput("on_drop_t1", 64'(ev_dropped), 64'd0);
            @(posedge clk); #1;
            checkOutput("on_ready_t2", 64'(ev_ready), 64'd0);
            @(posedge clk); #1;
            checkOutput("on_ready_t3", 64'(ev_ready), 64'd1);
            checkVoices("on");
        end
    endtask

    // Hard time limit, in case the design stops responding completely.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        ev_valid   = 1'b0;
        ev_note_on = 1'b0;
        ev_note    = '0;
        modelReset();

        $display("[TB] reset and single note-on");
        doReset();
        applyStimulus(1'b1, 7'd60);
        checkOutput("first_pi0", 64'(voice_phase_inc[0]), 64'h0123_4567);
        checkOutput("first_gate", 64'(voice_gate), 64'h1);

        $display("[TB] retrigger of note 60");
        applyStimulus(1'b1, 7'd60);
        checkOutput("retrig_gate", 64'(voice_gate), 64'h1);

        $display("[TB] chord and note-off");
        applyStimulus(1'b1, 7'd64);
        applyStimulus(1'b1, 7'd67);
        applyStimulus(1'b0, 7'd64);
        checkOutput("chord_gate", 64'(voice_gate), 64'h5);
        checkOutput("chord_pi1", 64'(voice_phase_inc[1]), 64'(lutf(7'd64)));

        $display("[TB] note-off with no match");
        applyStimulus(1'b0, 7'd72);
        checkOutput("nomatch_gate", 64'(voice_gate), 64'h5);

        $display("[TB] all voices busy");
        doReset();
        for (int n = 60; n <= 65; n++) applyStimulus(1'b1, 7'(n));
`ifdef VOICE_STEAL_EN
        checkOutput("steal_note0", 64'(voice_note[0]), 64'd64);
        checkOutput("steal_note1", 64'(voice_note[1]), 64'd65);
`else
        checkOutput("full_note0", 64'(voice_note[0]), 64'd60);
`endif

        $display("[TB] back-to-back note-offs");
        applyStimulus(1'b0, 7'd62);
        applyStimulus(1'b0, 7'd63);

        $display("[TB] reset during CAPTURE");
        waitReady();
        ev_valid   = 1'b1;
        ev_note_on = 1'b1;
        ev_note    = 7'd70;
        @(posedge clk); #1;
        ev_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        checkAllZero("capt_rst");
        reset_n = 1'b1;
        modelReset();
        @(posedge clk); #1;
        applyStimulus(1'b1, 7'd70);
        checkOutput("post_rst_gate", 64'(voice_gate), 64'h1);
        checkOutput("post_rst_note0", 64'(voice_note[0]), 64'd70);

        $display("[TB] random mix");
        for (int k = 0; k < 30; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 7'($urandom_range(60, 67)));
        end

        repeat (4) @(posedge clk);
        #1;
        checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);
        checkOutput("drop_count", 64'(drop_seen), 64'(drop_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
